// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of pipeline registers with per-stage
// hold/flush, automatic bubble insertion, occupancy and a bubble counter.
module pipe_stage_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CW        = 16
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           hold,
    input  logic [DEPTH-1:0]           flush,
    input  logic                       clr_stats,
    output logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CW-1:0]              bubble_cnt
);

    localparam int OW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] heff;
    logic [DEPTH-2:0] boundary;
    logic             bubble;

    // Effective hold: a stall in any older stage freezes all younger ones.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        heff = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            acc     = acc | hold[k];
            heff[k] = acc;
        end
    end

    // A bubble enters the first stage that advances behind a held one,
    // unless that stage is being squashed anyway.
    assign boundary = heff[DEPTH-2:0] & ~heff[DEPTH-1:1] & ~flush[DEPTH-1:1];
    assign bubble   = |boundary;
    assign in_ready = ~heff[0];

    // Stage registers: flush beats hold, hold beats bubble, bubble beats shift.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= NOP_VALUE;
            end
            valid_q <= '0;
        end else begin
            if (flush[0]) begin
                data_q[0]  <= NOP_VALUE;
                valid_q[0] <= 1'b0;
            end else if (!heff[0]) begin
                data_q[0]  <= in_valid ? in_data : NOP_VALUE;
                valid_q[0] <= in_valid;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (flush[k]) begin
                    data_q[k]  <= NOP_VALUE;
                    valid_q[k] <= 1'b0;
                end else if (!heff[k]) begin
                    if (heff[k-1]) begin
                        data_q[k]  <= NOP_VALUE;
                        valid_q[k] <= 1'b0;
                    end else begin
                        data_q[k]  <= data_q[k-1];
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end
        end
    end

    // Saturating bubble counter; a stats clear wins over a same-edge bubble.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            bubble_cnt <= '0;
        end else if (clr_stats) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CW{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CW'(1);
        end
    end

    // Occupancy is a population count of the valid bits.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(valid_q[k]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign stage_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign stage_valid = valid_q;
    assign out_data    = data_q[DEPTH-1];
    assign out_valid   = valid_q[DEPTH-1];

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of DEPTH pipeline stage registers, each WIDTH bits wide. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers and the control-unit NOP mux into one block.
- Adds a valid bit per stage, per-stage hold (stall) and flush (squash), automatic bubble insertion, an occupancy count and a saturating bubble counter.
- Sits between the datapath stages; stage 0 is the youngest (IF/ID) and stage DEPTH-1 is the oldest (MEM/WB).

Parameters:
- WIDTH, 32, payload bits per stage (packed control plus data fields).
- DEPTH, 4, number of stages; minimum 2.
- NOP_VALUE, 0, payload loaded on reset, flush and bubble (WIDTH bits).
- CW, 16, bubble-counter width.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  payload entering stage 0.
- in_valid  input  1  in_data is a real instruction.
- in_ready  output  1  stage 0 accepts this cycle; equals ~heff[0].
- hold  input  DEPTH  per-stage stall request; bit k freezes stage k.
- flush  input  DEPTH  per-stage squash; bit k kills stage k at the next edge.
- clr_stats  input  1  synchronous clear of bubble_cnt.
- stage_data  output  DEPTH*WIDTH  all stage payloads; stage k at bits [k*WIDTH +: WIDTH].
- stage_valid  output  DEPTH  valid bit of each stage.
- out_data  output  WIDTH  equals stage DEPTH-1 payload.
- out_valid  output  1  equals stage DEPTH-1 valid.
- occupancy  output  $clog2(DEPTH+1)  number of set stage_valid bits.
- bubble_cnt  output  CW  bubbles inserted since reset or clr_stats.

Behaviour:
- Reset (CLR=1, asynchronous):
  - all stage payloads = NOP_VALUE; all valid bits = 0.
  - bubble_cnt = 0; occupancy = 0.
  - in_ready follows its combinational definition.
- Effective hold (combinational): heff[k] = OR of hold[j] for j >= k. A stall in an older stage freezes every younger stage. heff is monotonic, so at most one hold/advance boundary exists.
- Per-stage update at the rising edge, priority top-down:
  - Stage 0:
    - flush[0]: payload = NOP_VALUE, valid = 0.
    - else heff[0]: keep current contents.
    - else: payload = in_data, valid = in_valid.
  - Stage k > 0:
    - flush[k]: payload = NOP_VALUE, valid = 0.
    - else heff[k]: keep current contents.
    - else heff[k-1]: bubble; payload = NOP_VALUE, valid = 0.
    - else: copy stage k-1.
- Flush overrides hold on the same stage. Flushing a held stage squashes it, and it stays empty while the hold persists.
- Latency:
  - An accepted instruction reaches out_data DEPTH cycles after acceptance when there are no holds.
  - Each cycle of heff at its stage adds one cycle.
- Bubble counter (bubble_cnt):
  - Increments by 1 on each edge where a boundary k exists (heff[k-1]=1, heff[k]=0, flush[k]=0).
  - Saturates at 2^CW-1 with no wrap.
  - clr_stats has priority over increment; the counter reads 0 after that edge.
- in_valid with heff[0]=1: not accepted. The source must hold in_data until in_ready=1.
- hold[DEPTH-1]=1 freezes the entire chain. No bubble is inserted and the counter is unchanged.
- All outputs are registered, except in_ready and occupancy (combinational from registered state).
- CLR asserted mid-stall or mid-flush clears everything at once. The first edge after release behaves as from reset.
- Invalid (valid=0) stages still shift and hold like valid ones; payload is always NOP_VALUE when valid=0.

Test Plan (defaults: WIDTH=32, DEPTH=4, NOP_VALUE=0):
1. Reset and flow:
   - Stimulus: CLR pulse; then in_valid=1 with 0xE0825005, 0xE2533001, 0x1AFFFFFD on three consecutive edges.
   - Required: 0xE0825005 on out_data with out_valid=1 at edge 4; occupancy reaches 3 at edge 3; before that out_data=0, out_valid=0.
2. Mid stall:
   - Stimulus: pipe full with A,B,C,D (stage 0 to 3); hold[1]=1 for 2 cycles.
   - Required: stages 0-1 keep A,B; stage 2 gets NOP/valid 0 twice; bubble_cnt=2; in_ready=0 during the hold.
3. Flush over hold:
   - Stimulus: hold[1]=1 and flush[1]=1 on the same edge.
   - Required: stage 1 = NOP, valid 0; stage 0 unchanged; stage 2 = NOP (bubble); bubble_cnt +1.
4. Branch squash:
   - Stimulus: flush=4'b0011 with stages valid.
   - Required: stages 0-1 invalid next cycle; stages 2-3 advance normally; occupancy drops by 2 (plus the normal shift effect).
5. Full freeze:
   - Stimulus: hold[3]=1 for 5 cycles.
   - Required: all stages constant; bubble_cnt unchanged; in_ready=0.
6. Counter saturation and clear:
   - Stimulus: CW=4 build; hold[0] constantly set produces 20 bubbles; then clr_stats=1 concurrent with a new bubble.
   - Required: bubble_cnt stops at 15; after clr_stats it reads 0.
7. Async reset mid-stall:
   - Stimulus: assert CLR between clock edges while hold[2]=1.
   - Required: outputs clear immediately without waiting for an edge.
